// File: rtl/psum_pkg.sv
// ---------------------------------------------------------------------------
// psum_pkg
//   Shared constants and helper functions for the partial-sum accumulator.
//   - cnt_width    : width of the beat counter for a group of K beats
//   - round_offset : half-LSB rounding constant for a right shift of SHIFT
//   - sat_max/min  : signed clip bounds of an OW-bit result
//   - aw_legal     : accumulator width check (AW >= BW2 + clog2(K))
// ---------------------------------------------------------------------------
package psum_pkg;

    function automatic int cnt_width(input int k);
        return (k < 1) ? 1 : $clog2(k + 1);
    endfunction

    function automatic longint round_offset(input int shift);
        return (shift > 0) ? (longint'(1) << (shift - 1)) : longint'(0);
    endfunction

    function automatic longint sat_max(input int ow);
        return (longint'(1) << (ow - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int ow);
        return -(longint'(1) << (ow - 1));
    endfunction

    function automatic bit aw_legal(input int aw, input int bw2, input int k);
        return (k >= 1) && (aw >= bw2 + $clog2(k));
    endfunction

endpackage

// File: rtl/psum_requant.sv
// ---------------------------------------------------------------------------
// psum_requant
//   Combinational requantiser: round half up, arithmetic right shift,
//   optional ReLU, then signed saturation to OW bits.
//   Optional feature macro: PSUM_ACC_RELU_EN (negative shifted values are
//   forced to zero before the clip; this clamp never raises sat).
//
//   Ports:
//     sum  [AW]  signed group sum
//     data [OW]  signed requantised result
//     sat        result was clipped to the OW-bit range
// ---------------------------------------------------------------------------
module psum_requant
    import psum_pkg::*;
#(
    parameter int AW    = 24,
    parameter int SHIFT = 4,
    parameter int OW    = 8
) (
    input  logic [AW-1:0] sum,
    output logic [OW-1:0] data,
    output logic          sat
);

    // One guard bit so adding the rounding offset can never wrap.
    localparam int EW = AW + 1;

    localparam logic signed [EW-1:0] RND_V = EW'(round_offset(SHIFT));
    localparam logic signed [EW-1:0] MAX_V = EW'(sat_max(OW));
    localparam logic signed [EW-1:0] MIN_V = EW'(sat_min(OW));

    logic signed [EW-1:0] sum_ext;
    logic signed [EW-1:0] rnd_sum;
    logic signed [EW-1:0] shifted;
    logic signed [EW-1:0] clamp_in;

    always_comb begin
        sum_ext = signed'({sum[AW-1], sum});
        rnd_sum = sum_ext + RND_V;
        shifted = rnd_sum >>> SHIFT;
`ifdef PSUM_ACC_RELU_EN
        clamp_in = shifted[EW-1] ? '0 : shifted;
`else
        clamp_in = shifted;
`endif
        data = clamp_in[OW-1:0];
        sat  = 1'b0;
        if (clamp_in > MAX_V) begin
            data = MAX_V[OW-1:0];
            sat  = 1'b1;
        end else if (clamp_in < MIN_V) begin
            data = MIN_V[OW-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// ---------------------------------------------------------------------------
// psum_accumulator
//   Accumulates K consecutive signed partial sums per output pixel from a
//   valid/ready stream, requantises the group sum (round, shift, clip) and
//   holds the result in an output register so the next group can keep
//   accumulating while the previous result waits for the sink.
//   Optional feature macro: PSUM_ACC_RELU_EN (ReLU before the clip).
//
//   Ports:
//     i_clk    clock, rising edge
//     i_rst    synchronous active-high reset
//     i_valid  i_psum valid
//     o_ready  block accepts i_psum this cycle
//     i_psum   signed partial sum [BW2]
//     o_valid  o_data valid
//     i_ready  downstream accepts o_data
//     o_data   signed requantised result [OW]
//     o_sat    o_data was clipped (qualified by o_valid)
//     o_cnt    beats accepted in the current group (debug)
// ---------------------------------------------------------------------------
module psum_accumulator
    import psum_pkg::*;
#(
    parameter int BW2   = 17,
    parameter int AW    = 24,
    parameter int K     = 4,
    parameter int SHIFT = 4,
    parameter int OW    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [BW2-1:0]          i_psum,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [OW-1:0]           o_data,
    output logic                    o_sat,
    output logic [cnt_width(K)-1:0] o_cnt
);

    localparam int CW = cnt_width(K);
    localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

    generate
        if (!aw_legal(AW, BW2, K)) begin : g_bad_aw
            $error("psum_accumulator: AW must be >= BW2 + clog2(K) and K >= 1");
        end
    endgenerate

    logic [AW-1:0] acc_reg,   acc_next;
    logic [CW-1:0] cnt_reg,   cnt_next;
    logic          valid_reg, valid_next;
    logic [OW-1:0] data_reg,  data_next;
    logic          sat_reg,   sat_next;

    logic [AW-1:0] psum_ext;
    logic [AW-1:0] sum;
    logic [OW-1:0] q_data;
    logic          q_sat;
    logic          is_final;
    logic          accept;
    logic          transfer;

    // Sign extension of the incoming partial sum.
    assign psum_ext[BW2-1:0] = i_psum;
    genvar gi;
    generate
        for (gi = BW2; gi < AW; gi++) begin : g_sext
            assign psum_ext[gi] = i_psum[BW2-1];
        end
    endgenerate

    assign sum      = acc_reg + psum_ext;
    assign is_final = (cnt_reg == LAST_CNT);
    // Only the final beat can stall: it needs the output register, which is
    // busy when it holds a result that is not leaving this cycle.
    assign o_ready  = !(is_final && valid_reg && !i_ready);
    assign accept   = i_valid && o_ready;
    assign transfer = valid_reg && i_ready;

    psum_requant #(
        .AW    (AW),
        .SHIFT (SHIFT),
        .OW    (OW)
    ) u_requant (
        .sum  (sum),
        .data (q_data),
        .sat  (q_sat)
    );

    always_comb begin
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        valid_next = valid_reg;
        data_next  = data_reg;
        sat_next   = sat_reg;
        if (accept) begin
            if (is_final) begin
                acc_next = '0;
                cnt_next = '0;
            end else begin
                acc_next = sum;
                cnt_next = cnt_reg + CW'(1);
            end
        end
        // A final beat reloads the output register even while the old result
        // is draining, so o_valid stays high across back-to-back results.
        if (accept && is_final) begin
            valid_next = 1'b1;
            data_next  = q_data;
            sat_next   = q_sat;
        end else if (transfer) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
            sat_reg   <= 1'b0;
        end else begin
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
            data_reg  <= data_next;
            sat_reg   <= sat_next;
        end
    end

    assign o_valid = valid_reg;
    assign o_data  = data_reg;
    assign o_sat   = sat_reg;
    assign o_cnt   = cnt_reg;

endmodule
